sseg_scan: RTL and testbench

Time-multiplexed scan controller for a multi-digit 7-segment display that shares one `sseg` hex decoder across `NUM_DIGITS` digits. It drives the decoder's `in` and `oe` inputs and a one-hot digit-select bus, visiting each digit for a fixed dwell with an anti-ghosting blank gap between digits. Display data is double-buffered and takes effect only at frame boundaries, so a frame never shows a mix of old and new values.

---
 rtl/sseg_scan.sv | 249 ++++++++++++++++++++++++
 tb/tb_sseg_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan.sv
// -----------------------------------------------------------------------------
// sseg_scan -- time-multiplexed scan controller for a multi-digit 7-segment
// display that shares one hex decoder across NUM_DIGITS digits.
//
// Each digit gets a slot of BLANK + DWELL cycles. The first BLANK cycles of a
// slot are dark, so the previous digit's segments cannot ghost onto the next
// one. The remaining DWELL cycles light the digit. The decoder nibble is
// presented during the blank as well, so the decoder has settled by the time
// the digit is enabled.
//
// Display data is double-buffered. A write lands in a shadow register. That
// value is copied to the active register only at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS  number of digits scanned (>= 2)
//   DWELL       lit cycles per slot      (>= 1)
//   BLANK       dark cycles per slot     (>= 1)
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   digits      new display value, nibble k = digit k (digit 0 least significant)
//   wr_en       capture digits into the shadow register on this edge
//   sseg_in     nibble for the shared decoder
//   sseg_oe     decoder output enable
//   digit_sel   one-hot active-high digit enable
//   pending     shadow holds data not yet applied to the display
//   frame_done  one-cycle pulse after the scan wraps back to digit 0
//
// Build option:
//   SSEG_SCAN_LZB_EN  when defined, enables leading-zero blanking. Any digit
//                     above digit 0 whose own value and all higher digits are
//                     zero stays dark. Its slot still takes the full time, so
//                     every lit digit gets the same brightness.
//
// Every output comes straight from a flop. The value loaded into each output
// flop is computed from the next-state values, so each output reflects the
// state that the FSM enters on the same edge.
// -----------------------------------------------------------------------------
module sseg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    wr_en,
    output logic [3:0]              sseg_in,
    output logic                    sseg_oe,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(BLANK + DWELL);
    localparam int DAT_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Parameter sanity checks, evaluated at elaboration time only.
    if (NUM_DIGITS < 2) begin : g_bad_num_digits
        $error("sseg_scan: NUM_DIGITS must be at least 2");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("sseg_scan: DWELL must be at least 1");
    end
    if (BLANK < 1) begin : g_bad_blank
        $error("sseg_scan: BLANK must be at least 1");
    end

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DAT_W-1:0]      r_shadow;
    logic [DAT_W-1:0]      r_active;
    logic                  r_pending;
    logic [3:0]            r_sseg_in;
    logic                  r_sseg_oe;
    logic [NUM_DIGITS-1:0] r_digit_sel;
    logic                  r_frame_done;

    // -------------------------------------------------------------------------
    // Combinational next values
    // -------------------------------------------------------------------------
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_blank_end;
    logic                  w_show_end;
    logic                  w_boundary;
    logic [DAT_W-1:0]      w_active_nxt;
    logic                  w_pending_nxt;
    logic [NUM_DIGITS-1:0] w_lit_mask;
    logic                  w_sseg_oe_nxt;
    logic [NUM_DIGITS-1:0] w_digit_sel_nxt;
    logic [3:0]            w_sseg_in_nxt;

    // -------------------------------------------------------------------------
    // FSM process 1: state register (state, slot counter, digit index)
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments.
    // Every flop then samples the values from before the edge, whatever order
    // the processes run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default value first. That way no
    // path through the block can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;

        w_blank_end = (r_state == S_BLANK) && (r_cnt == BLANK_LAST);
        w_show_end  = (r_state == S_SHOW)  && (r_cnt == SHOW_LAST);
        // The frame ends when the last digit finishes its lit time.
        w_boundary  = w_show_end && (r_idx == IDX_LAST);

        unique case (r_state)
            S_BLANK: begin
                if (w_blank_end) begin
                    w_state_nxt = S_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            S_SHOW: begin
                if (w_show_end) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Double-buffered display data
    // -------------------------------------------------------------------------
    // A write on the boundary edge still goes into the shadow. The active
    // register takes the shadow value from before that write, and only if a
    // value was already waiting. The new write waits for the next boundary.
    always_comb begin
        w_active_nxt  = (w_boundary && r_pending) ? r_shadow : r_active;
        w_pending_nxt = wr_en || (r_pending && !w_boundary);
    end

    // NOTE: the data registers are reset like any other flop. A reset that
    // arrives mid-scan must blank the display and drop any half-applied write,
    // so no stale digits survive it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (wr_en) begin
                r_shadow <= digits;
            end
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Per-digit lit mask (leading-zero blanking)
    // -------------------------------------------------------------------------
`ifdef SSEG_SCAN_LZB_EN
    // Walk from the most significant digit down. Keep a running flag that says
    // whether any digit at or above the current one is non-zero. Digit 0 is
    // always lit, so a zero value still shows a single '0'.
    always_comb begin : lzb_mask
        logic v_nz_seen;
        v_nz_seen  = 1'b0;
        w_lit_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_nz_seen     = v_nz_seen || (w_active_nxt[4*k +: 4] != 4'h0);
            w_lit_mask[k] = v_nz_seen || (k == 0);
        end
    end
`else
    assign w_lit_mask = '1;
`endif

    // -------------------------------------------------------------------------
    // FSM process 3: output logic (next values for the output flops)
    // -------------------------------------------------------------------------
    always_comb begin
        w_sseg_oe_nxt   = (w_state_nxt == S_SHOW) && w_lit_mask[w_idx_nxt];
        w_digit_sel_nxt = '0;
        if (w_sseg_oe_nxt) begin
            w_digit_sel_nxt = NUM_DIGITS'(1) << w_idx_nxt;
        end
        // The nibble follows the digit index in both states, so the decoder
        // has settled before the digit is enabled.
        w_sseg_in_nxt = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
    end

    // sseg_oe and digit_sel come from the same next-state term and load on the
    // same edge, so they can never be skewed relative to each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sseg_in    <= '0;
            r_sseg_oe    <= 1'b0;
            r_digit_sel  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_sseg_in    <= w_sseg_in_nxt;
            r_sseg_oe    <= w_sseg_oe_nxt;
            r_digit_sel  <= w_digit_sel_nxt;
            r_frame_done <= w_boundary;
        end
    end

    assign sseg_in    = r_sseg_in;
    assign sseg_oe    = r_sseg_oe;
    assign digit_sel  = r_digit_sel;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sseg_scan.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan -- self-checking bench for sseg_scan.
//
// Configuration: NUM_DIGITS=4, DWELL=4, BLANK=2, giving a 6-cycle slot and a
// 24-cycle frame.
//
// Each table row holds the inputs driven before clock edge e (counted from 0 at
// the first edge after reset release) and the outputs expected right after
// that edge. After edge e the scan has run p = e + 1 cycles since release.
// The row's slot is (p / 6) % 4 and its phase is p % 6; phases 0-1 are blank.
// frame_done is high when p is a non-zero multiple of 24.
//
// The expected active data and pending flag for each row are written out by
// hand for each sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sseg_scan;

    localparam int ND    = 4;
    localparam int SLOT  = 6;
    localparam int FRAME = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   digits;
    logic          wr_en;
    logic [3:0]    sseg_in;
    logic          sseg_oe;
    logic [ND-1:0] digit_sel;
    logic          pending;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          wr_en;
        logic [15:0] digits;
        logic [3:0]  exp_sel;
        logic        exp_oe;
        logic [3:0]  exp_in;
        logic        exp_pend;
        logic        exp_fd;
    } vec_t;

    vec_t vecs [0:79];

    sseg_scan #(
        .NUM_DIGITS(ND),
        .DWELL     (4),
        .BLANK     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits    (digits),
        .wr_en     (wr_en),
        .sseg_in   (sseg_in),
        .sseg_oe   (sseg_oe),
        .digit_sel (digit_sel),
        .pending   (pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Build one row from the position in the scan plus the expected data state.
    function automatic vec_t mk(input int e, input bit we, input logic [15:0] d,
                                input logic [15:0] act, input bit pend);
        vec_t v;
        int   p;
        int   slot;
        int   phase;
        p     = e + 1;
        slot  = (p / SLOT) % ND;
        phase = p % SLOT;
        v.wr_en  = we;
        v.digits = d;
`ifdef SSEG_SCAN_LZB_EN
        v.exp_oe = (phase >= 2) && ((slot == 0) || ((act >> (4 * slot)) != 16'h0));
`else
        v.exp_oe = (phase >= 2);
`endif
        v.exp_sel  = v.exp_oe ? 4'(1 << slot) : 4'b0000;
        v.exp_in   = act[slot*4 +: 4];
        v.exp_pend = pend;
        v.exp_fd   = (p % FRAME == 0);
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".in"},   0, 16'(sseg_in),    16'h0);
        check({tag, ".oe"},   0, 16'(sseg_oe),    16'h0);
        check({tag, ".sel"},  0, 16'(digit_sel),  16'h0);
        check({tag, ".pend"}, 0, 16'(pending),    16'h0);
        check({tag, ".fd"},   0, 16'(frame_done), 16'h0);
    endtask

    // Hold reset for a few cycles and check every output is zero. Then release
    // it on a falling edge and check the first cycle after release is blank.
    task automatic do_reset(input string tag);
        rst_n  = 1'b0;
        wr_en  = 1'b0;
        digits = 16'h0;
        repeat (3) @(negedge clk);
        check_all_zero({tag, ".rst"});
        rst_n = 1'b1;
        check({tag, ".rel.oe"},  0, 16'(sseg_oe),   16'h0);
        check({tag, ".rel.sel"}, 0, 16'(digit_sel), 16'h0);
    endtask

    task automatic run_table(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            digits = vecs[i].digits;
            wr_en  = vecs[i].wr_en;
            @(posedge clk);
            @(negedge clk);
            check({tag, ".sel"},  i, 16'(digit_sel),  16'(vecs[i].exp_sel));
            check({tag, ".oe"},   i, 16'(sseg_oe),    16'(vecs[i].exp_oe));
            check({tag, ".in"},   i, 16'(sseg_in),    16'(vecs[i].exp_in));
            check({tag, ".pend"}, i, 16'(pending),    16'(vecs[i].exp_pend));
            check({tag, ".fd"},   i, 16'(frame_done), 16'(vecs[i].exp_fd));
        end
        wr_en  = 1'b0;
        digits = 16'h0;
    endtask

    initial begin
        // ---- Boot, plus a write before the first boundary ----
        // 4321 is written at edge 3 and applied at boundary edge 23.
        do_reset("boot");
        for (int e = 0; e < 48; e++) begin
            vecs[e] = mk(e, e == 3, (e == 3) ? 16'h4321 : 16'h0,
                         (e >= 23) ? 16'h4321 : 16'h0,
                         (e >= 3) && (e < 23));
        end
        run_table("boot", 48);

        // ---- Write landing on the boundary edge ----
        // AAAA is written mid-frame at edge 10. 5555 is written on boundary
        // edge 23. Frame 1 shows AAAA and frame 2 shows 5555. pending stays
        // high until edge 47.
        do_reset("bnd");
        for (int e = 0; e < 72; e++) begin
            vecs[e] = mk(e, (e == 10) || (e == 23),
                         (e == 10) ? 16'hAAAA : (e == 23) ? 16'h5555 : 16'h0,
                         (e < 23) ? 16'h0 : (e < 47) ? 16'hAAAA : 16'h5555,
                         (e >= 10) && (e < 47));
        end
        run_table("bnd", 72);

        // ---- Reset in the middle of digit 2's lit time ----
        // At edge 38 the scan is lighting digit 2 of frame 1, and a 9999 write
        // from edge 36 is still pending.
        do_reset("mid");
        for (int e = 0; e < 39; e++) begin
            vecs[e] = mk(e, (e == 3) || (e == 36),
                         (e == 3) ? 16'h4321 : (e == 36) ? 16'h9999 : 16'h0,
                         (e >= 23) ? 16'h4321 : 16'h0,
                         ((e >= 3) && (e < 23)) || (e >= 36));
        end
        run_table("mid", 39);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid.async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // After release the scan restarts at digit 0 with active=0. The 9999
        // write was lost to the reset.
        for (int e = 0; e < 30; e++) begin
            vecs[e] = mk(e, 1'b0, 16'h0, 16'h0, 1'b0);
        end
        run_table("post", 30);

`ifdef SSEG_SCAN_LZB_EN
        // ---- Leading-zero blanking ----
        // Frame 0 shows 0000, so only digit 0 is lit. Frame 1 shows 0050, so
        // digits 1 and 0 are lit. Frame 2 shows 0000 again.
        do_reset("lzb");
        for (int e = 0; e < 72; e++) begin
            vecs[e] = mk(e, (e == 3) || (e == 30),
                         (e == 3) ? 16'h0050 : 16'h0,
                         (e < 23) ? 16'h0 : (e < 47) ? 16'h0050 : 16'h0,
                         ((e >= 3) && (e < 23)) || ((e >= 30) && (e < 47)));
        end
        run_table("lzb", 72);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
